// File: rtl/emul_seq_multiplier.sv
// emul_seq_multiplier: shift-add unsigned multiplier, responder side of the
// emul operand/product interface. One partial-product iteration per enabled
// clock, WIDTH iterations per request, four-phase start/done handshake.
module emul_seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic [WIDTH-1:0]     emul_a,
  input  logic [WIDTH-1:0]     emul_b,
  output logic [2*WIDTH-1:0]   emul_x,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   prod;
  logic [2*WIDTH:0]   prod_step;
  logic [WIDTH:0]     upper_sum;
  logic [CW-1:0]      count;
  logic               last_iter;

  // One iteration: conditional add into the upper field, then shift right.
  // prod[2W] is always zero at the start of an iteration, so adding to the
  // full upper field equals adding to prod[2W-1:W] with the carry captured.
  always_comb begin
    upper_sum = prod[2*WIDTH:WIDTH] + (prod[0] ? {1'b0, mcand} : '0);
    prod_step = {upper_sum, prod[WIDTH-1:0]} >> 1;
    last_iter = (count == LAST);
  end

  // Next-state logic for the IDLE -> RUN -> DONE handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    if (!start)    state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // State register; reset wins over enable.
  always_ff @(posedge clock) begin
    if (reset)       state <= IDLE;
    else if (enable) state <= state_next;
  end

  // Operand capture, iteration datapath and product register.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand  <= '0;
      prod   <= '0;
      count  <= '0;
      emul_x <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= emul_a;
            prod  <= {{(WIDTH+1){1'b0}}, emul_b};
            count <= '0;
          end
        end
        RUN: begin
          prod  <= prod_step;
          count <= count + CW'(1);
          if (last_iter) emul_x <= prod_step[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  // Status flags decoded straight from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule
